// File: rtl/exe_stage.sv
// RV32 execute stage: ALU, branch compare, EX/MEM pipeline register and optional RV32M unit.
// Define EXE_MULDIV_EN to build the multiplier and the iterative divider (ops 11-18).
module exe_stage #(
  parameter int XLEN             = 32,
  parameter int DIV_BITS_PER_CYC = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Flush,
  input  logic [XLEN-1:0] RD1_ID,
  input  logic [XLEN-1:0] RD2_ID,
  input  logic [XLEN-1:0] Immediate_ID,
  input  logic            ALUSrc_ID,
  input  logic [4:0]      ALUOp_ID,
  input  logic [2:0]      BrFunct3_ID,
  input  logic            Branch_ID,
  input  logic            Jump_ID,
  input  logic            MemWrite_ID,
  input  logic            RegWrite_ID,
  input  logic [1:0]      MemtoReg_ID,
  input  logic            sw_ID,
  input  logic            sh_ID,
  input  logic            sb_ID,
  input  logic            lw_ID,
  input  logic            lh_ID,
  input  logic            lhu_ID,
  input  logic            lb_ID,
  input  logic            lbu_ID,
  input  logic [4:0]      WriteReg_ID,
  output logic            Stall_EXE,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] Immediate_EXE,
  output logic            Zero,
  output logic            Branch_EXE,
  output logic            Jump_EXE,
  output logic            MemWrite_EXE,
  output logic            RegWrite_EXE,
  output logic [1:0]      MemtoReg_EXE,
  output logic            sw_EXE,
  output logic            sh_EXE,
  output logic            sb_EXE,
  output logic            lw_EXE,
  output logic            lh_EXE,
  output logic            lhu_EXE,
  output logic            lb_EXE,
  output logic            lbu_EXE,
  output logic [4:0]      WriteReg_EXE
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;
  localparam int         CTRL_W    = 19;

  logic [XLEN-1:0]        op_a, op_b, alu_res, result_d, result_q;
  logic signed [XLEN-1:0] op_a_s, op_b_s, rd1_s, rd2_s;
  logic                   br_taken, bubble;
  logic [CTRL_W-1:0]      ctrl_in, ctrl_d, ctrl_q;
  logic [XLEN-1:0]        wdata_q, imm_q;
  logic                   zero_q;

  assign op_a   = RD1_ID;
  assign op_b   = ALUSrc_ID ? Immediate_ID : RD2_ID;
  assign op_a_s = op_a;
  assign op_b_s = op_b;
  assign rd1_s  = RD1_ID;
  assign rd2_s  = RD2_ID;

`ifdef EXE_MULDIV_EN
  // One 2*XLEN multiplier; operand extension selects the RV32M signedness.
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              mul_a_sx, mul_b_sx;
  assign mul_a_sx = (ALUOp_ID == OP_MULH) || (ALUOp_ID == OP_MULHSU);
  assign mul_b_sx = (ALUOp_ID == OP_MULH);
  assign mul_a    = {{XLEN{mul_a_sx & op_a[XLEN-1]}}, op_a};
  assign mul_b    = {{XLEN{mul_b_sx & op_b[XLEN-1]}}, op_b};
  assign prod     = mul_a * mul_b;
`endif

  always_comb begin
    alu_res = '0;
    case (ALUOp_ID)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_SLL:   alu_res = op_a << op_b[4:0];
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SRL:   alu_res = op_a >> op_b[4:0];
      OP_SRA:   alu_res = op_a_s >>> op_b[4:0];
      OP_OR:    alu_res = op_a | op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_PASSB: alu_res = op_b;
`ifdef EXE_MULDIV_EN
      OP_MUL:    alu_res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (BrFunct3_ID)
      3'b000:  br_taken = (RD1_ID == RD2_ID);
      3'b001:  br_taken = (RD1_ID != RD2_ID);
      3'b100:  br_taken = (rd1_s < rd2_s);
      3'b101:  br_taken = (rd1_s >= rd2_s);
      3'b110:  br_taken = (RD1_ID < RD2_ID);
      3'b111:  br_taken = (RD1_ID >= RD2_ID);
      default: br_taken = 1'b0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  localparam int               DIV_STEPS = XLEN / DIV_BITS_PER_CYC;
  localparam int               CNT_W     = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_STEPS - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d, dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;
  logic             is_div_op, div_signed, div_stall;
  logic [XLEN-1:0]  abs_a, abs_b, div_res;
  logic [2*XLEN:0]  step_first, step_busy;

  // Restoring division on magnitudes; quo holds the remaining dividend bits and the quotient.
  function automatic logic [2*XLEN:0] div_step(input logic [XLEN:0]   rem,
                                               input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    r = rem;
    q = quo;
    for (int i = 0; i < DIV_BITS_PER_CYC; i++) begin
      r = {r[XLEN-1:0], q[XLEN-1]};
      q = {q[XLEN-2:0], 1'b0};
      if (r >= {1'b0, dvs}) begin
        r    = r - {1'b0, dvs};
        q[0] = 1'b1;
      end
    end
    return {r, q};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ('0 - v) : v;
  endfunction

  assign is_div_op  = (ALUOp_ID >= OP_DIV) && (ALUOp_ID <= OP_REMU);
  assign div_signed = (ALUOp_ID == OP_DIV) || (ALUOp_ID == OP_REM);
  assign abs_a      = cond_neg(op_a, div_signed & op_a[XLEN-1]);
  assign abs_b      = cond_neg(op_b, div_signed & op_b[XLEN-1]);
  assign step_first = div_step('0, abs_a, abs_b);
  assign step_busy  = div_step(rem_q, quo_q, dvs_q);
  assign div_res    = is_rem_q ? cond_neg(rem_q[XLEN-1:0], r_neg_q) : cond_neg(quo_q, q_neg_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvs_q    <= dvs_d;
    q_neg_q  <= q_neg_d;
    r_neg_q  <= r_neg_d;
    is_rem_q <= is_rem_d;
  end

  // The accept cycle already retires the first quotient digit, so the stall lasts DIV_STEPS cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    is_rem_d  = is_rem_q;
    div_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_div_op && !Flush) begin
          div_stall      = 1'b1;
          {rem_d, quo_d} = step_first;
          dvs_d          = abs_b;
          q_neg_d        = div_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]) & (op_b != '0);
          r_neg_d        = div_signed & op_a[XLEN-1];
          is_rem_d       = (ALUOp_ID == OP_REM) || (ALUOp_ID == OP_REMU);
          cnt_d          = '0;
          state_d        = BUSY;
        end
      end
      BUSY: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          div_stall      = 1'b1;
          {rem_d, quo_d} = step_busy;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Stall_EXE = div_stall;
  assign result_d  = (state_q == DONE) ? div_res : alu_res;
`else
  assign Stall_EXE = 1'b0;
  assign result_d  = alu_res;
`endif

  assign ctrl_in = {Branch_ID, Jump_ID, MemWrite_ID, RegWrite_ID, MemtoReg_ID, WriteReg_ID,
                    sw_ID, sh_ID, sb_ID, lw_ID, lh_ID, lhu_ID, lb_ID, lbu_ID};
  assign bubble  = Flush | Stall_EXE;
  assign ctrl_d  = bubble ? '0 : ctrl_in;

  // EX/MEM boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      wdata_q  <= '0;
      imm_q    <= '0;
      zero_q   <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      result_q <= result_d;
      wdata_q  <= RD2_ID;
      imm_q    <= Immediate_ID;
      zero_q   <= br_taken;
      ctrl_q   <= ctrl_d;
    end
  end

  assign ALUResult     = result_q;
  assign WriteData     = wdata_q;
  assign Immediate_EXE = imm_q;
  assign Zero          = zero_q;
  assign {Branch_EXE, Jump_EXE, MemWrite_EXE, RegWrite_EXE, MemtoReg_EXE, WriteReg_EXE,
          sw_EXE, sh_EXE, sb_EXE, lw_EXE, lh_EXE, lhu_EXE, lb_EXE, lbu_EXE} = ctrl_q;

endmodule
